// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : ID stage - register file with write-through bypass, opcode
//               decode, load-use hazard detection and the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     programCounterIn,
    input  logic [31:0]               instruction,
    input  logic                      flush,
    input  logic                      regWriteEnable,
    input  logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
    input  logic [DATA_WIDTH-1:0]     regWriteData,
    output logic                      pcWrite,
    output logic                      ifIdWrite,
    output logic [DATA_WIDTH-1:0]     programCounterOut,
    output logic [DATA_WIDTH-1:0]     readData1,
    output logic [DATA_WIDTH-1:0]     readData2,
    output logic [DATA_WIDTH-1:0]     immediate,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [5:0]                aluFunct,
    output logic [1:0]                aluOp,
    output logic                      regWrite,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      memToReg,
    output logic                      aluSrc,
    output logic                      regDst,
    output logic                      branch,
    output logic                      illegalInstruction
);
    localparam int         c_NUM_REGS  = 2 ** REG_ADDR_WIDTH;
    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_LW     = 6'h23;
    localparam logic [5:0] c_OP_SW     = 6'h2B;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_ADDI   = 6'h08;

    logic [DATA_WIDTH-1:0]     regs_q [c_NUM_REGS];
    logic [5:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_rs, w_rt, w_rd;
    logic [DATA_WIDTH-1:0]     w_rdata1, w_rdata2, w_imm;
    logic [1:0]                w_aluOp;
    logic                      w_regWrite, w_memRead, w_memWrite, w_memToReg;
    logic                      w_aluSrc, w_regDst, w_branch, w_illegal;
    logic                      w_usesRt, w_stall, w_bubble;

    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_imm    = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};

    // Register 0 is hard-wired; a same-cycle writeback is forwarded to readers.
    always_comb begin
        w_rdata1 = regs_q[w_rs];
        w_rdata2 = regs_q[w_rt];
        if (regWriteEnable && regWriteAddr == w_rs) w_rdata1 = regWriteData;
        if (regWriteEnable && regWriteAddr == w_rt) w_rdata2 = regWriteData;
        if (w_rs == '0) w_rdata1 = '0;
        if (w_rt == '0) w_rdata2 = '0;
    end

    always_comb begin
        w_aluOp    = 2'b00;
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_memToReg = 1'b0;
        w_aluSrc   = 1'b0;
        w_regDst   = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        unique case (w_opcode)
            c_OP_RTYPE: begin w_regWrite = 1'b1; w_regDst = 1'b1; w_aluOp = 2'b10; end
            c_OP_LW: begin
                w_regWrite = 1'b1; w_memRead = 1'b1; w_memToReg = 1'b1; w_aluSrc = 1'b1;
            end
            c_OP_SW:   begin w_memWrite = 1'b1; w_aluSrc = 1'b1; end
            c_OP_BEQ:  begin w_branch = 1'b1; w_aluOp = 2'b01; end
            c_OP_ADDI: begin w_regWrite = 1'b1; w_aluSrc = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    // Only R-type, sw and beq actually consume rt as a source operand.
    assign w_usesRt  = (w_opcode == c_OP_RTYPE) || (w_opcode == c_OP_SW) || (w_opcode == c_OP_BEQ);
    assign w_stall   = memRead && (rt != '0) && ((rt == w_rs) || ((rt == w_rt) && w_usesRt));
    assign w_bubble  = w_stall || flush;
    assign pcWrite   = ~(w_stall && !flush);
    assign ifIdWrite = ~(w_stall && !flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) regs_q[i] <= '0;
            programCounterOut  <= '0;
            readData1          <= '0;
            readData2          <= '0;
            immediate          <= '0;
            rs                 <= '0;
            rt                 <= '0;
            rd                 <= '0;
            aluFunct           <= '0;
            aluOp              <= '0;
            regWrite           <= 1'b0;
            memRead            <= 1'b0;
            memWrite           <= 1'b0;
            memToReg           <= 1'b0;
            aluSrc             <= 1'b0;
            regDst             <= 1'b0;
            branch             <= 1'b0;
            illegalInstruction <= 1'b0;
        end else begin
            if (regWriteEnable && regWriteAddr != '0) regs_q[regWriteAddr] <= regWriteData;
            programCounterOut  <= programCounterIn;
            readData1          <= w_rdata1;
            readData2          <= w_rdata2;
            immediate          <= w_imm;
            rs                 <= w_rs;
            rt                 <= w_rt;
            rd                 <= w_rd;
            aluFunct           <= instruction[5:0];
            aluOp              <= w_bubble ? 2'b00 : w_aluOp;
            regWrite           <= w_regWrite & ~w_bubble;
            memRead            <= w_memRead  & ~w_bubble;
            memWrite           <= w_memWrite & ~w_bubble;
            memToReg           <= w_memToReg & ~w_bubble;
            aluSrc             <= w_aluSrc   & ~w_bubble;
            regDst             <= w_regDst   & ~w_bubble;
            branch             <= w_branch   & ~w_bubble;
            illegalInstruction <= w_illegal  & ~w_bubble;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Directed vectors with a queued scoreboard for instruction_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;
    localparam logic [6:0] c_R    = 7'b1000010;
    localparam logic [6:0] c_LW   = 7'b1101100;
    localparam logic [6:0] c_SW   = 7'b0010100;
    localparam logic [6:0] c_BEQ  = 7'b0000001;
    localparam logic [6:0] c_ADDI = 7'b1000100;
    localparam logic [6:0] c_NONE = 7'b0000000;
    localparam int c_NORMAL = 0, c_BUBBLE = 1, c_ZERO = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        logic [1:0]  aop;
        logic [6:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, regWriteEnable;
    logic [31:0] programCounterIn, instruction, regWriteData;
    logic [4:0]  regWriteAddr;
    logic        pcWrite, ifIdWrite;
    logic [31:0] programCounterOut, readData1, readData2, immediate;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  aluFunct;
    logic [1:0]  aluOp;
    logic        regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch;
    logic        illegalInstruction;

    exp_t idq[$];
    logic pcq[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] pcv = 32'h100;

    instruction_decode dut (
        .clk(clk), .reset(reset), .programCounterIn(programCounterIn),
        .instruction(instruction), .flush(flush), .regWriteEnable(regWriteEnable),
        .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .programCounterOut(programCounterOut),
        .readData1(readData1), .readData2(readData2), .immediate(immediate),
        .rs(rs), .rt(rt), .rd(rd), .aluFunct(aluFunct), .aluOp(aluOp),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .aluSrc(aluSrc), .regDst(regDst), .branch(branch),
        .illegalInstruction(illegalInstruction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One stimulus cycle; chk_pc=0 skips the combinational stall check.
    task automatic step(input logic rst, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic chk_pc, input logic pcw, input int kind,
                        input logic [6:0] ctrl, input logic [1:0] aop, input logic ill,
                        input logic [31:0] rd1, input logic [31:0] rd2);
        exp_t e;
        @(negedge clk);
        reset = rst; instruction = ins; flush = fl; programCounterIn = pcv;
        regWriteEnable = we; regWriteAddr = wa; regWriteData = wd;
        if (chk_pc) pcq.push_back(pcw);
        e.kind = kind[1:0];
        e.pc = pcv; e.rd1 = rd1; e.rd2 = rd2;
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11]; e.fn = ins[5:0];
        e.aop = aop; e.ctrl = ctrl; e.ill = ill;
        if (kind == c_ZERO) begin
            e.pc = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
            e.rs = '0; e.rt = '0; e.rd = '0; e.fn = '0;
            e.aop = '0; e.ctrl = '0; e.ill = 1'b0;
        end
        idq.push_back(e);
        pcv = pcv + 32'd4;
    endtask

    always @(negedge clk) begin
        #2;
        if (pcq.size() != 0) begin
            logic exp_pcw;
            exp_pcw = pcq.pop_front();
            chk("pcWrite", {31'd0, pcWrite}, {31'd0, exp_pcw});
            chk("ifIdWrite", {31'd0, ifIdWrite}, {31'd0, exp_pcw});
        end
    end

    always @(posedge clk) begin
        #1;
        if (idq.size() != 0) begin
            exp_t e;
            e = idq.pop_front();
            chk("ctrl", {25'd0, regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch},
                {25'd0, e.ctrl});
            chk("illegal", {31'd0, illegalInstruction}, {31'd0, e.ill});
            if (e.kind != 2'(c_BUBBLE)) begin
                chk("aluOp", {30'd0, aluOp}, {30'd0, e.aop});
                chk("pcOut", programCounterOut, e.pc);
                chk("readData1", readData1, e.rd1);
                chk("readData2", readData2, e.rd2);
                chk("immediate", immediate, e.imm);
                chk("rs", {27'd0, rs}, {27'd0, e.rs});
                chk("rt", {27'd0, rt}, {27'd0, e.rt});
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                chk("aluFunct", {26'd0, aluFunct}, {26'd0, e.fn});
            end
        end
    end

    initial begin
        reset = 1'b1; instruction = '0; flush = 1'b0; programCounterIn = '0;
        regWriteEnable = 1'b0; regWriteAddr = '0; regWriteData = '0;
        // reset
        step(1, 32'h0, 0, 0, 0, 0,            0, 1, c_ZERO,   c_NONE, 2'b00, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0,            1, 1, c_ZERO,   c_NONE, 2'b00, 0, 0, 0);
        // preload $1=5, $2=7
        step(0, 32'h0, 0, 1, 1, 32'd5,        1, 1, c_NORMAL, c_R,    2'b10, 0, 0, 0);
        step(0, 32'h0, 0, 1, 2, 32'd7,        1, 1, c_NORMAL, c_R,    2'b10, 0, 0, 0);
        // add $3,$1,$2
        step(0, 32'h00221820, 0, 0, 0, 0,     1, 1, c_NORMAL, c_R,    2'b10, 0, 32'd5, 32'd7);
        // bypass of $1
        step(0, 32'h00221820, 0, 1, 1, 32'hDEADBEEF, 1, 1, c_NORMAL, c_R, 2'b10, 0, 32'hDEADBEEF, 32'd7);
        // write to $0 neither bypasses nor sticks; $1 now committed
        step(0, 32'h00012820, 0, 1, 0, 32'h1234, 1, 1, c_NORMAL, c_R, 2'b10, 0, 32'd0, 32'hDEADBEEF);
        // load-use: lw $2,4($1) then add $4,$2,$3 (stall one cycle, then add)
        step(0, 32'h8C220004, 0, 0, 0, 0,     1, 1, c_NORMAL, c_LW,   2'b00, 0, 32'hDEADBEEF, 32'd7);
        step(0, 32'h00432020, 0, 0, 0, 0,     1, 0, c_BUBBLE, c_NONE, 2'b00, 0, 0, 0);
        step(0, 32'h00432020, 0, 0, 0, 0,     1, 1, c_NORMAL, c_R,    2'b10, 0, 32'd7, 32'd0);
        // flush coinciding with a load-use hazard
        step(0, 32'h8C220004, 0, 0, 0, 0,     1, 1, c_NORMAL, c_LW,   2'b00, 0, 32'hDEADBEEF, 32'd7);
        step(0, 32'h00432020, 1, 0, 0, 0,     1, 1, c_BUBBLE, c_NONE, 2'b00, 0, 0, 0);
        // decode sweep: sw, beq, addi (negative imm), illegal opcode 0x3F
        step(0, 32'hAC220008, 0, 0, 0, 0,     1, 1, c_NORMAL, c_SW,   2'b00, 0, 32'hDEADBEEF, 32'd7);
        step(0, 32'h1022FFFF, 0, 0, 0, 0,     1, 1, c_NORMAL, c_BEQ,  2'b01, 0, 32'hDEADBEEF, 32'd7);
        step(0, 32'h2026FFFC, 0, 0, 0, 0,     1, 1, c_NORMAL, c_ADDI, 2'b00, 0, 32'hDEADBEEF, 32'd0);
        step(0, 32'hFC000000, 0, 0, 0, 0,     1, 1, c_NORMAL, c_NONE, 2'b00, 1, 32'd0, 32'd0);
        // reset arriving in a stall cycle
        step(0, 32'h8C220004, 0, 0, 0, 0,     1, 1, c_NORMAL, c_LW,   2'b00, 0, 32'hDEADBEEF, 32'd7);
        step(1, 32'h00432020, 0, 0, 0, 0,     1, 0, c_ZERO,   c_NONE, 2'b00, 0, 0, 0);
        step(0, 32'h00221820, 0, 0, 0, 0,     1, 1, c_NORMAL, c_R,    2'b10, 0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        if (idq.size() != 0 || pcq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", idq.size() + pcq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
